// File: rtl/rf_op_sequencer.sv
// Register-file operation sequencer: LOADI/ADD/SUB/READ through IDLE -> FETCH -> WRITE.
// Optional carry/borrow flag enabled by defining RF_SEQ_CARRY_EN.
module rf_op_sequencer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [ADDR_W-1:0] rf_raddr1_q, rf_raddr1_d;
    logic [ADDR_W-1:0] rf_raddr2_q, rf_raddr2_d;
    logic              result_valid_q, result_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] alu_res;

`ifdef RF_SEQ_CARRY_EN
    logic              carry_q, carry_d;
    logic [DATA_W:0]   alu_ext;

    // One extra bit holds the ADD carry-out or the SUB borrow (set when op1 < op2).
    always_comb begin
        if (op_q == OP_SUB) begin
            alu_ext = {1'b0, rf_rdata1} - {1'b0, rf_rdata2};
        end else begin
            alu_ext = {1'b0, rf_rdata1} + {1'b0, rf_rdata2};
        end
    end

    assign alu_res = alu_ext[DATA_W-1:0];
    assign carry   = carry_q;
`else
    always_comb begin
        if (op_q == OP_SUB) begin
            alu_res = rf_rdata1 - rf_rdata2;
        end else begin
            alu_res = rf_rdata1 + rf_rdata2;
        end
    end

    assign carry = 1'b0;
`endif

    // Next-state and next-output logic; outputs are set up one cycle ahead so they register into their state.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        dst_d          = dst_q;
        cmd_ready_d    = 1'b0;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        rf_raddr1_d    = rf_raddr1_q;
        rf_raddr2_d    = rf_raddr2_q;
        result_valid_d = 1'b0;
        result_d       = result_q;
`ifdef RF_SEQ_CARRY_EN
        carry_d        = carry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d  = cmd_op;
                    dst_d = cmd_dst;
                    if (cmd_op == OP_LOADI) begin
                        state_d        = S_WRITE;
                        rf_we_d        = 1'b1;
                        rf_waddr_d     = cmd_dst;
                        rf_wdata_d     = cmd_imm;
                        result_valid_d = 1'b1;
                        result_d       = cmd_imm;
                    end else begin
                        state_d     = S_FETCH;
                        rf_raddr1_d = cmd_src1;
                        rf_raddr2_d = cmd_src2;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_FETCH: begin
                // Operands are sampled here, before this command's own write lands.
                state_d        = S_WRITE;
                result_valid_d = 1'b1;
                if (op_q == OP_READ) begin
                    result_d = rf_rdata1;
                end else begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = dst_q;
                    rf_wdata_d = alu_res;
                    result_d   = alu_res;
`ifdef RF_SEQ_CARRY_EN
                    carry_d    = alu_ext[DATA_W];
`endif
                end
            end
            S_WRITE: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= OP_LOADI;
            dst_q          <= '0;
            cmd_ready_q    <= 1'b1;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            rf_raddr1_q    <= '0;
            rf_raddr2_q    <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
`ifdef RF_SEQ_CARRY_EN
            carry_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            dst_q          <= dst_d;
            cmd_ready_q    <= cmd_ready_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            rf_raddr1_q    <= rf_raddr1_d;
            rf_raddr2_q    <= rf_raddr2_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
`ifdef RF_SEQ_CARRY_EN
            carry_q        <= carry_d;
`endif
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign rf_raddr1    = rf_raddr1_q;
    assign rf_raddr2    = rf_raddr2_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer: driver pushes expected responses, a monitor pops them on result_valid.
// Carry expectations follow RF_SEQ_CARRY_EN when defined.
module tb_rf_op_sequencer;

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 3;
    localparam logic [1:0] LOADI = 2'b00;
    localparam logic [1:0] ADD   = 2'b01;
    localparam logic [1:0] SUB   = 2'b10;
    localparam logic [1:0] READ  = 2'b11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_dst = '0, cmd_src1 = '0, cmd_src2 = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr, rf_raddr1, rf_raddr2;
    logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic          result_valid;
    logic [DW-1:0] result;
    logic          carry;

    rf_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_imm(cmd_imm),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .result_valid(result_valid), .result(result), .carry(carry)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT's write port.
    logic [DW-1:0] rf_mem [2**AW];
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] data;
        logic          c;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] m_regs [2**AW];
    logic          m_carry = 1'b0;
    int            n_cmp = 0, n_fail = 0, n_we = 0, exp_writes = 0;
    bit            hold_busy = 0, have_last = 0;
    int            last_k = 0;
    logic [1:0]    last_op = LOADI;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic scramble();
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_dst   = AW'($urandom);
        cmd_src1  = AW'($urandom);
        cmd_src2  = AW'($urandom);
        cmd_imm   = DW'($urandom);
    endtask

    task automatic issue(input logic [1:0] op, input int dst, input int s1, input int s2,
                         input int imm, input bit push);
        int   waited = 0;
        int   k, a, b, r;
        exp_t e;
        @(negedge clk);
        while (!cmd_ready) begin
            if (hold_busy) scramble();
            waited++;
            if (waited > 20) begin
                chk("ready_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        k = cyc;
        if (have_last) chk("b2b_gap", k - last_k, (last_op == LOADI) ? 2 : 3);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = AW'(dst);
        cmd_src1  = AW'(s1);
        cmd_src2  = AW'(s2);
        cmd_imm   = DW'(imm);
        a = int'(m_regs[s1]);
        b = int'(m_regs[s2]);
        e.waddr = AW'(dst);
        e.we    = (op != READ);
        e.cyc   = k + ((op == LOADI) ? 1 : 2);
        case (op)
            LOADI:   r = imm;
            ADD:     r = a + b;
            SUB:     r = a - b;
            default: r = a;
        endcase
        e.data = DW'(r);
        if (push) begin
`ifdef RF_SEQ_CARRY_EN
            if (op == ADD) m_carry = (r >= (1 << DW));
            if (op == SUB) m_carry = (a < b);
`endif
            e.c = m_carry;
            if (e.we) begin
                m_regs[dst] = e.data;
                exp_writes++;
            end
            sbq.push_back(e);
        end
        last_k    = k;
        last_op   = op;
        have_last = 1;
        @(posedge clk);
        #1;
        if (hold_busy) scramble();
        else cmd_valid = 1'b0;
        if (op != LOADI) begin
            @(negedge clk);
            chk("fetch_raddr1", int'(rf_raddr1), s1);
            chk("fetch_raddr2", int'(rf_raddr2), s2);
            if (hold_busy) scramble();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rf_we"}, int'(rf_we), 0);
        chk({tag, "_result_valid"}, int'(result_valid), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_carry"}, int'(carry), 0);
        chk({tag, "_rf_waddr"}, int'(rf_waddr), 0);
        chk({tag, "_rf_wdata"}, int'(rf_wdata), 0);
        chk({tag, "_rf_raddr1"}, int'(rf_raddr1), 0);
        chk({tag, "_rf_raddr2"}, int'(rf_raddr2), 0);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    endtask

    // Monitor: every result_valid pops one expectation; any rf_we outside it is an error.
    initial begin
        exp_t e;
        bit   prev_rv = 0;
        forever begin
            @(negedge clk);
            if (rf_we) n_we++;
            if (prev_rv && !reset) chk("ready_after_write", int'(cmd_ready), 1);
            if (result_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rf_we", int'(rf_we), int'(e.we));
                    if (e.we) begin
                        chk("rf_waddr", int'(rf_waddr), int'(e.waddr));
                        chk("rf_wdata", int'(rf_wdata), int'(e.data));
                    end
                    chk("result", int'(result), int'(e.data));
                    chk("carry", int'(carry), int'(e.c));
                    chk("latency_cycle", cyc, e.cyc);
                end
            end else if (rf_we) begin
                chk("rf_we_without_valid", 1, 0);
            end
            prev_rv = result_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            rf_mem[i] = '0;
            m_regs[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;

        issue(LOADI, 5, 0, 0, 'hA, 1);
        issue(LOADI, 1, 0, 0, 7, 1);
        issue(LOADI, 2, 0, 0, 9, 1);
        issue(ADD, 3, 1, 2, 0, 1);          // 7+9 wraps to 0 with carry
        issue(LOADI, 1, 0, 0, 2, 1);
        issue(LOADI, 2, 0, 0, 5, 1);
        issue(SUB, 1, 1, 2, 0, 1);          // 2-5 = D with borrow, dst is a source
        issue(READ, 0, 1, 0, 0, 1);

        hold_busy = 1;                      // cmd_valid stays high with junk fields while busy
        issue(ADD, 4, 3, 5, 0, 1);
        issue(ADD, 7, 5, 5, 0, 1);          // src1 == src2
        issue(READ, 0, 7, 3, 0, 1);
        hold_busy = 0;
        issue(LOADI, 6, 0, 0, 'hF, 1);

        // Abort an ADD in FETCH: no write, outputs cleared, no accept while reset is held.
        issue(ADD, 4, 1, 2, 0, 0);
        reset = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = LOADI;
        cmd_dst   = 3'd6;
        cmd_imm   = 4'h1;
        @(negedge clk);
        chk_reset_vals("abort");
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b0;
        m_carry = 1'b0;
        have_last = 0;

        issue(LOADI, 0, 0, 0, 3, 1);
        issue(READ, 0, 0, 0, 0, 1);
        issue(READ, 0, 4, 6, 0, 1);         // r4 must still hold A

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("queue_drain", sbq.size(), 0);
        chk("rf_we_count", n_we, exp_writes);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
